// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-side types and default constants for the UART receiver.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int PAR_EVEN       = 0;
    localparam int PAR_ODD        = 1;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for an asynchronous input, with selectable reset value.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;
    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk_i) begin
        if (rst_i) ff_q <= {2{RESET_VAL}};
        else       ff_q <= {ff_q[0], d_i};
    end
    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive sequencer with a single-entry valid/ready holding register.
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic                 baurd_clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
    logic                 par_q, par_d, valid_q, valid_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
    logic                 rx_s, deliver, take;

    rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i (baurd_clk),
        .rst_i (reset),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    // State, counters, shift register and holding register; reset drops any partial frame.
    always_ff @(posedge baurd_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame sequencing with mid-bit sampling, then delivery into the holding register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        deliver = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    par_d   = 1'b0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = (^sh_q) ^ rx_s ^ (PARITY_ODD != 0);
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    deliver = rx_s;
                    perr_d  = rx_s & par_q;
                    ferr_d  = ~rx_s;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        take    = valid_q & rx_ready;
        data_d  = data_q;
        valid_d = valid_q & ~take;
        ovr_d   = ovr_q & ~err_clr;
        if (deliver) begin
            if (!valid_q || take) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl (default build plus an even-parity build).
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_rise_a = 0, n_rise_b = 0, n_ferr_a = 0, n_perr_a = 0, n_perr_b = 0;
    int rise_cyc_a = 0, rise_cyc_b = 0;
    logic pv_a = 1'b0, pv_b = 1'b0;
    int start_cyc, r0, f0, p0;

    uart_rx_ctrl dut_a (
        .baurd_clk(clk), .reset(reset), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
        .err_clr(clr_a), .busy(busy_a)
    );

    uart_rx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .baurd_clk(clk), .reset(reset), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
        .err_clr(clr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Count edges and record valid rises and error pulses shortly after each active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (valid_a && !pv_a) begin n_rise_a++; rise_cyc_a = cyc; end
        if (valid_b && !pv_b) begin n_rise_b++; rise_cyc_b = cyc; end
        pv_a = valid_a;
        pv_b = valid_b;
        if (ferr_a) n_ferr_a++;
        if (perr_a) n_perr_a++;
        if (perr_b) n_perr_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rx_b = b;
        else     rx_a = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit use_par, input bit par, input bit stop);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (use_par) drive(sel, par);
        drive(sel, stop);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_ferr", ferr_a, 0);
        chk("rst_perr", perr_a, 0);
        chk("rst_ovr", ovr_a, 0);
        chk("rst_busy", busy_a, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        r0 = n_rise_a; f0 = n_ferr_a; p0 = n_perr_a;
        start_cyc = cyc;
        send(0, 8'hA5, 0, 0, 1);
        chk("a5_latency", rise_cyc_a - start_cyc, 155);
        chk("a5_rise", n_rise_a - r0, 1);
        chk("a5_data", data_a, 8'hA5);
        chk("a5_ferr", n_ferr_a - f0, 0);
        chk("a5_perr", n_perr_a - p0, 0);
        repeat (10) @(negedge clk);

        r0 = n_rise_a; f0 = n_ferr_a; p0 = n_perr_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", busy_a, 1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_idle", busy_a, 0);
        chk("glitch_rise", n_rise_a - r0, 0);
        chk("glitch_ferr", n_ferr_a - f0, 0);
        chk("glitch_perr", n_perr_a - p0, 0);

        r0 = n_rise_a; f0 = n_ferr_a;
        send(0, 8'h3C, 0, 0, 0);
        repeat (40) @(negedge clk);
        chk("break_busy", busy_a, 1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_ferr", n_ferr_a - f0, 1);
        chk("break_rise", n_rise_a - r0, 0);
        chk("break_idle", busy_a, 0);
        r0 = n_rise_a;
        send(0, 8'h11, 0, 0, 1);
        chk("after_break_rise", n_rise_a - r0, 1);
        chk("after_break_data", data_a, 8'h11);
        repeat (10) @(negedge clk);

        r0 = n_rise_b; p0 = n_perr_b;
        start_cyc = cyc;
        send(1, 8'h07, 1, 1, 1);
        chk("par_ok_latency", rise_cyc_b - start_cyc, 171);
        chk("par_ok_rise", n_rise_b - r0, 1);
        chk("par_ok_data", data_b, 8'h07);
        chk("par_ok_perr", n_perr_b - p0, 0);
        repeat (10) @(negedge clk);
        r0 = n_rise_b; p0 = n_perr_b;
        send(1, 8'h07, 1, 0, 1);
        chk("par_bad_rise", n_rise_b - r0, 1);
        chk("par_bad_data", data_b, 8'h07);
        chk("par_bad_perr", n_perr_b - p0, 1);
        repeat (10) @(negedge clk);

        ready_a = 1'b0;
        chk("ovr_pre_valid", valid_a, 0);
        send(0, 8'h12, 0, 0, 1);
        send(0, 8'h34, 0, 0, 1);
        chk("ovr_data", data_a, 8'h12);
        chk("ovr_valid", valid_a, 1);
        chk("ovr_flag", ovr_a, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ovr_clr", ovr_a, 0);
        chk("ovr_clr_valid", valid_a, 1);
        ready_a = 1'b1;
        @(negedge clk);
        chk("ovr_take_valid", valid_a, 0);
        chk("ovr_take_data", data_a, 8'h12);
        repeat (10) @(negedge clk);

        ready_a = 1'b0;
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        repeat (56) @(negedge clk);
        chk("midrst_busy", busy_a, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_busy0", busy_a, 0);
        chk("midrst_data", data_a, 0);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_ovr", ovr_a, 0);
        chk("midrst_ferr", ferr_a, 0);
        chk("midrst_perr", perr_a, 0);
        reset = 1'b0;
        ready_a = 1'b1;
        repeat (20) @(negedge clk);
        r0 = n_rise_a; f0 = n_ferr_a;
        send(0, 8'h5A, 0, 0, 1);
        chk("post_rst_rise", n_rise_a - r0, 1);
        chk("post_rst_data", data_a, 8'h5A);
        chk("post_rst_ferr", n_ferr_a - f0, 0);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive sequencer for the UART receiver, clocked by the 16x-oversampled baud clock.
- Synchronises the serial line, detects and qualifies the start bit, and samples each data/parity/stop bit at mid-bit.
- Assembles the byte and hands it to the host through a single-entry valid/ready holding register, with error and overrun reporting.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, baurd_clk cycles per bit; even, >=4
PARITY_EN, 0, 1 = one parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
baurd_clk  in  1  oversample clock; sole clock
reset  in  1  synchronous, active-high reset
rx_in  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, valid while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  host accepts rx_data when rx_valid&rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
parity_err  out  1  one-cycle pulse: parity mismatch
overrun  out  1  sticky: completed frame dropped because holding register full
err_clr  in  1  clears overrun
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (on baurd_clk edge with reset=1): state IDLE; counters 0; both sync flops 1; rx_data=0; rx_valid=0; frame_err=0; parity_err=0; overrun=0; busy=0. Reset mid-frame discards the partial frame.
- rx_in passes two flops to give rx_s; the FSM sees only rx_s.
- Counter cnt, width clog2(OVERSAMPLE); bit_idx counts data bits.
- IDLE: if rx_s=0, go to START with cnt<=0.
- START: cnt increments each cycle. At cnt=OVERSAMPLE/2-1:
  - rx_s=0: go to DATA, cnt<=0, bit_idx<=0.
  - rx_s=1 (glitch): go to IDLE; nothing reported.
- DATA: at cnt=OVERSAMPLE-1, shift rx_s into the MSB of the shift register (shift right) and reset cnt to 0. After sample DATA_BITS, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at cnt=OVERSAMPLE-1. Mismatch when (XOR of data ^ rx_s ^ PARITY_ODD) != 0; latch the result, go to STOP.
- STOP: sample at cnt=OVERSAMPLE-1.
  - rx_s=1: deliver the frame; parity_err pulses if the parity flag is set; go to IDLE.
  - rx_s=0: frame_err pulses; data discarded (no parity_err); go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low break yields exactly one frame_err.
- Deliver:
  - If rx_valid=0, or rx_valid&rx_ready in the same cycle: load rx_data; rx_valid<=1.
  - Otherwise: rx_data is unchanged, the new word is dropped, and overrun<=1.
- rx_valid clears on rx_valid&rx_ready when there is no simultaneous deliver.
- err_clr clears overrun. When set and clear coincide, set wins.
- Latency: edge E0 first samples rx_in low. The stop sample occurs at E0 + 2 + OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+PARITY_EN+1), which is 154 with the defaults. rx_valid is high immediately after that edge.
- Back-to-back frames: a new start bit is detected on the IDLE cycle right after the stop sample; no extra gap is required.
- busy=1 in START, DATA, PARITY, STOP and WAIT_HIGH.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default constants: DATA_BITS=8, OVERSAMPLE=16.
  - Parity-mode constants.
- Sub-module rx_sync: 2-flop synchronizer, reset value 1, parameterised reset value.
- FSM, counters and holding register stay in uart_rx_ctrl.

Test Plan:
- Frame 0xA5, defaults, rx_ready=1: rx_valid rises after E154 with rx_data=0xA5; no error flags.
- 4-cycle low glitch on an idle line: FSM returns to IDLE; rx_valid, frame_err and parity_err all stay 0.
- Frame 0x3C with stop bit 0, then line held low for 40 cycles: exactly one frame_err pulse, no rx_valid. The next good frame 0x11 is received correctly.
- PARITY_EN=1, even parity: 0x07 with parity bit 1 gives rx_data=0x07 and no error. The same word with parity bit 0 gives rx_data=0x07 with a parity_err pulse.
- rx_ready=0; send 0x12 then 0x34 back-to-back: rx_data stays 0x12 and overrun=1. Assert err_clr: overrun=0. Assert rx_ready: rx_valid falls.
- Reset asserted during DATA bit 3 of 0xFF: all outputs at reset values. The next frame 0x5A is received intact.
